// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Optional statistics are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_DATA_W  = 16;
  localparam int ARB_CNT_W   = 16;

  function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N  = ARB_NUM_REQ,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          valid
);

  int cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    valid   = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!valid && req[IW'(cand)]) begin
        valid   = 1'b1;
        win_idx = IW'(cand);
      end
    end
    if (valid) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; grants only after the FIFO's wr_ack.
// Define FIFO_ARB_STATS_EN to add per-producer grant counters and a retry counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int FIFO_WIDTH = ARB_DATA_W,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [IW-1:0]                 owner,
  output logic                          busy,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          wr_ack
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*ARB_CNT_W-1:0]  gnt_cnt,
  output logic [ARB_CNT_W-1:0]          retry_cnt
`endif
);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  lock_q, lock_d;

  logic [NUM_REQ-1:0]    owner_oh, pick_req, pick_oh;
  logic [IW-1:0]         nxt_ptr, pick_ptr, pick_idx;
  logic                  pick_vld;

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    nxt_ptr           = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    // Back-to-back decision excludes the producer just granted; its req is stale.
    pick_req          = (state_q == WAIT) ? (req & ~owner_oh) : req;
    pick_ptr          = (state_q == WAIT) ? nxt_ptr : ptr_q;
  end

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .req     (pick_req),
    .ptr     (pick_ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .valid   (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    lock_d  = lock_q;
    gnt     = '0;
    case (state_q)
      IDLE: begin
        if (!full) begin
          // A refused word owns the port until it is accepted.
          if (lock_q) begin
            state_d = ISSUE;
          end else if (pick_vld) begin
            state_d = ISSUE;
            owner_d = pick_idx;
            data_d  = req_data[pick_idx*FIFO_WIDTH +: FIFO_WIDTH];
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (wr_ack) begin
          gnt    = owner_oh;
          ptr_d  = nxt_ptr;
          lock_d = 1'b0;
          if (pick_vld && !full) begin
            state_d = ISSUE;
            owner_d = pick_idx;
            data_d  = req_data[pick_idx*FIFO_WIDTH +: FIFO_WIDTH];
          end else begin
            state_d = IDLE;
          end
        end else begin
          lock_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_en_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      lock_q  <= lock_d;
    end
  end

  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);
  assign wr_en   = wr_en_q;
  assign data_in = data_q;

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*ARB_CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;
  logic [ARB_CNT_W-1:0]         retry_cnt_q, retry_cnt_d;

  always_comb begin
    gnt_cnt_d   = gnt_cnt_q;
    retry_cnt_d = retry_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_cnt_d[i*ARB_CNT_W +: ARB_CNT_W] = sat_inc(gnt_cnt_q[i*ARB_CNT_W +: ARB_CNT_W]);
    end
    if (state_q == WAIT && !wr_ack) retry_cnt_d = sat_inc(retry_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt_q   <= '0;
      retry_cnt_q <= '0;
    end else begin
      gnt_cnt_q   <= gnt_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign gnt_cnt   = gnt_cnt_q;
  assign retry_cnt = retry_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues, a depth-8 FIFO model and a grant scoreboard.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int DEPTH = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           busy, wr_en, full_in, wr_ack;
  logic [W-1:0]   data_in;
  logic           fifo_full, force_full, rd_req;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] gnt_cnt;
  logic [15:0]     retry_cnt;
`endif

  assign full_in = fifo_full | force_full;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .owner    (owner),
    .busy     (busy),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .full     (full_in),
    .wr_ack   (wr_ack)
`ifdef FIFO_ARB_STATS_EN
    ,
    .gnt_cnt  (gnt_cnt),
    .retry_cnt(retry_cnt)
`endif
  );

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  logic [W+1:0] exp_q[$];
  logic [W-1:0] fifo_exp_q[$];
  logic [W-1:0] mem[$];
  logic [W-1:0] pq[N][$];
  int           wr_cyc_q[$];
  logic [W-1:0] last_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [N-1:0] v);
    oh2idx = '0;
    for (int i = 0; i < N; i++) if (v[i]) oh2idx = 2'(i);
  endfunction

  task automatic push_exp(input int idx, input logic [W-1:0] d);
    exp_q.push_back({2'(idx), d});
    fifo_exp_q.push_back(d);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO model: registered wr_ack/full, outputs settle just after the edge.
  logic         m_acc, m_rdn;
  logic [W-1:0] m_wd, m_rd;
  initial begin
    wr_ack    = 1'b0;
    fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      m_acc = wr_en && !full_in;
      m_wd  = data_in;
      m_rdn = rd_req && (mem.size() > 0);
      @(posedge clk);
      #1;
      if (m_rdn) begin
        m_rd = mem.pop_front();
        if (fifo_exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL fifo_rd_extra: got 0x%0h with nothing expected", m_rd);
        end else begin
          check("fifo_rd_order", m_rd, fifo_exp_q.pop_front());
        end
      end
      if (m_acc) mem.push_back(m_wd);
      wr_ack    = m_acc;
      fifo_full = (mem.size() >= DEPTH);
    end
  end

  // Producer driver: hold word until gnt, advance just after the gnt cycle ends.
  logic [N-1:0] g_cap;
  initial begin
    req      = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      g_cap = gnt;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (g_cap[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        req[i]              = (pq[i].size() > 0);
        req_data[i*W +: W]  = (pq[i].size() > 0) ? pq[i][0] : '0;
      end
    end
  end

  // Monitor / scoreboard
  logic [W+1:0] exp_item;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (wr_en) begin
        wr_cyc_q.push_back(cyc);
        check("no_overflow", fifo_full, 0);
        if (!full_in) last_wr = data_in;
      end
      if (gnt != '0) begin
        check("gnt_onehot", $onehot(gnt), 1);
        if (exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL gnt_unexpected: got gnt=%b, expected none", gnt);
        end else begin
          exp_item = exp_q.pop_front();
          check("gnt_word", {oh2idx(gnt), last_wr}, exp_item);
        end
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d grants outstanding after %0d cycles, expected 0", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(posedge clk);
    #2 rd_req = 1'b1;
    while (mem.size() > 0 && n < 64) begin
      @(posedge clk);
      #2;
      n++;
    end
    rd_req = 1'b0;
    check({name, "_fifo_left"}, fifo_exp_q.size(), 0);
    fifo_exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int n;
    force_full = 1'b0;
    rd_req     = 1'b0;
    last_wr    = '0;

    // reset values
    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_data_in", data_in, 0);
    check("rst_gnt", gnt, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
`ifdef FIFO_ARB_STATS_EN
    check("rst_retry_cnt", retry_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // single producer, latency
    pq[2].push_back(16'hA5A5);
    push_exp(2, 16'hA5A5);
    @(negedge clk);
    check("t1_wr_en_before", wr_en, 0);
    @(negedge clk);
    check("t1_wr_en", wr_en, 1);
    check("t1_data_in", data_in, 16'hA5A5);
    check("t1_owner", owner, 2);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_gnt", gnt, 4'b0100);
    check("t1_wr_en_after", wr_en, 0);
    wait_done("t1", 20);
    drain("t1");

    // all four continuous: order 0,1,2,3,0,1,2,3 at 2 cycles/word
    reset_dut();
    @(negedge clk);
    wr_cyc_q.delete();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        pq[i].push_back(16'((r + 1) * 16'h1000 + i));
        push_exp(i, 16'((r + 1) * 16'h1000 + i));
      end
    end
    wait_done("t2", 100);
    check("t2_writes", wr_cyc_q.size(), 8);
    for (int k = 1; k < wr_cyc_q.size(); k++) check("t2_gap", wr_cyc_q[k] - wr_cyc_q[k-1], 2);
    drain("t2");

    // prefilled FIFO: one write fits, then full holds off issue until a read
    for (int k = 0; k < 7; k++) begin
      mem.push_back(16'(16'h0700 + k));
      fifo_exp_q.push_back(16'(16'h0700 + k));
    end
    @(negedge clk);
    wr_cyc_q.delete();
    pq[0].push_back(16'h3000);
    pq[1].push_back(16'h3001);
    push_exp(0, 16'h3000);
    push_exp(1, 16'h3001);
    n = 0;
    while (exp_q.size() > 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3_first_grant", exp_q.size(), 1);
    repeat (6) @(negedge clk);
    check("t3_held_writes", wr_cyc_q.size(), 1);
    check("t3_full", fifo_full, 1);
    check("t3_idle_while_full", busy, 0);
    @(posedge clk);
    #2 rd_req = 1'b1;
    @(posedge clk);
    #2 rd_req = 1'b0;
    wait_done("t3", 50);
    check("t3_writes", wr_cyc_q.size(), 2);
    drain("t3");

    // refused write: lock keeps owner 3 even though producer 2 is ahead of it
    pq[3].push_back(16'hBEEF);
    pq[0].push_back(16'h0F0F);
    push_exp(3, 16'hBEEF);
    push_exp(0, 16'h0F0F);
    push_exp(2, 16'h2222);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("t4_issue", wr_en, 1);
    check("t4_issue_owner", owner, 3);
    force_full = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_nack_gnt", gnt, 0);
    check("t4_nack_busy", busy, 1);
    pq[2].push_back(16'h2222);
    @(negedge clk);
    check("t4_locked_busy", busy, 0);
    check("t4_locked_owner", owner, 3);
    check("t4_locked_data", data_in, 16'hBEEF);
    repeat (3) begin
      @(negedge clk);
      check("t4_hold_while_full", wr_en, 0);
    end
`ifdef FIFO_ARB_STATS_EN
    check("t4_retry_cnt", retry_cnt, 1);
`endif
    force_full = 1'b0;
    wait_done("t4", 50);
`ifdef FIFO_ARB_STATS_EN
    check("t4_gnt_cnt0", gnt_cnt[0*16 +: 16], 4);
    check("t4_gnt_cnt1", gnt_cnt[1*16 +: 16], 3);
    check("t4_gnt_cnt2", gnt_cnt[2*16 +: 16], 3);
    check("t4_gnt_cnt3", gnt_cnt[3*16 +: 16], 3);
`endif
    drain("t4");

    // reset during ISSUE: wr_en drops without a clock, pointer back to 0
    pq[1].push_back(16'h1111);
    pq[3].push_back(16'h3333);
    push_exp(1, 16'h1111);
    push_exp(3, 16'h3333);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("t5_issue", wr_en, 1);
    check("t5_issue_owner", owner, 3);
    rst = 1'b1;
    #1;
    check("t5_async_wr_en", wr_en, 0);
    check("t5_async_busy", busy, 0);
    @(negedge clk);
    check("t5_rst_owner", owner, 0);
    check("t5_rst_data", data_in, 0);
`ifdef FIFO_ARB_STATS_EN
    check("t5_rst_retry_cnt", retry_cnt, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_done("t5", 50);
    drain("t5");

    // one producer back-to-back: IDLE inserted, 3 cycles per word
    wr_cyc_q.delete();
    for (int k = 1; k <= 3; k++) begin
      pq[3].push_back(16'(16'h3A00 + k));
      push_exp(3, 16'(16'h3A00 + k));
    end
    wait_done("t6", 50);
    check("t6_writes", wr_cyc_q.size(), 3);
    for (int k = 1; k < wr_cyc_q.size(); k++) check("t6_gap", wr_cyc_q[k] - wr_cyc_q[k-1], 3);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
